jedro_1_ifu: RTL

Instruction fetch controller for the jedro_1 core; it sequences instruction memory and feeds the decoder.
- Owns the fetch PC and issues word requests over a req/gnt/rvalid memory interface.
- Buffers returned words, with their PCs, in a small FIFO.
- Presents words to the decoder through a valid/ready handshake.
- Handles control-flow redirects (jumps and taken branches), including flushing in-flight fetches.

---
 rtl/jedro_1_ifu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/jedro_1_ifu.sv
// -----------------------------------------------------------------------------
// jedro_1_ifu -- instruction fetch unit for the jedro_1 core.
//
// Owns the fetch PC, issues word reads over a req/gnt/rvalid memory interface,
// buffers returned words (with their PCs) in a small FIFO and hands them to the
// decoder through a valid/ready handshake. Jumps and taken branches redirect
// the fetch stream; words already in flight for the old stream are counted and
// discarded when they return.
//
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   instr_req_o         fetch request to instruction memory
//   instr_addr_o        word-aligned fetch address (held while req && !gnt)
//   instr_gnt_i         memory accepted the request this cycle
//   instr_rvalid_i      read data valid (one per grant, in order)
//   instr_rdata_i       returned instruction word
//   dec_instr_o         instruction at the FIFO head
//   dec_pc_o            PC of dec_instr_o
//   dec_valid_o         FIFO head is valid
//   dec_ready_i         decoder consumes the head when dec_valid_o is high
//   jmp_instr_i         redirect strobe (single cycle)
//   jmp_addr_i          redirect target
//   misaligned_o        one-cycle pulse (cycle after the strobe) for a
//                       redirect target with addr[1:0] != 0
// -----------------------------------------------------------------------------
module jedro_1_ifu #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,

    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,

    input  logic        jmp_instr_i,
    input  logic [31:0] jmp_addr_i,
    output logic        misaligned_o
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters hold values up to DEPTH; two spare bits keep sums safe.
    localparam int          CW  = $clog2(DEPTH) + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     target_q, target_d;
    logic            hold_q, hold_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     rd_pc_q, rd_pc_d;
    logic            misaligned_q, misaligned_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];

    logic            grant;
    logic            pop;
    logic            drop;
    logic            push;
    logic            jmp_ok;
    logic            jmp_bad;
    logic            req_stalled;
    logic [CW-1:0]   credit;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign dec_valid_o  = (count_q != '0);
    assign dec_instr_o  = instr_mem_q[rd_ptr_q];
    assign dec_pc_o     = pc_mem_q[rd_ptr_q];
    assign instr_addr_o = addr_q;
    assign misaligned_o = misaligned_q;

    assign pop    = dec_valid_o & dec_ready_i;
    // A word popped this cycle frees its slot for a request raised now.
    assign credit = count_q + outstanding_q - CW'(pop);

    // Once a request is up it stays up (hold_q) until granted, whatever the
    // credit or redirect situation.
    assign instr_req_o = (state_q != ST_BOOT) && (hold_q || (credit < CW'(DEPTH)));
    assign grant       = instr_req_o & instr_gnt_i;
    assign req_stalled = instr_req_o & ~instr_gnt_i;

    assign drop    = instr_rvalid_i & (discard_q != '0);
    assign push    = instr_rvalid_i & ~drop;
    assign jmp_ok  = jmp_instr_i & (jmp_addr_i[1:0] == 2'b00);
    assign jmp_bad = jmp_instr_i & (jmp_addr_i[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        target_d      = target_q;
        hold_d        = req_stalled;
        outstanding_d = outstanding_q + CW'(grant) - CW'(instr_rvalid_i);
        discard_d     = discard_q - CW'(drop);
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_pc_d       = rd_pc_q;
        misaligned_d  = jmp_bad;

        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end

        if (grant) begin
            if (state_q == ST_REDIRECT) begin
                // The held pre-redirect request has gone out; resume at target.
                addr_d  = target_q;
                state_d = ST_RUN;
            end else begin
                addr_d = addr_q + 32'd4;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rd_pc_d  = rd_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // An aligned redirect overrides everything above: flush the FIFO and
        // throw away every word of the old stream still to come back,
        // including a request that is still waiting for its grant.
        if (jmp_ok) begin
            discard_d = outstanding_d + CW'(req_stalled);
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            rd_pc_d   = jmp_addr_i;
            if (req_stalled) begin
                target_d = jmp_addr_i;
                state_d  = ST_REDIRECT;
            end else begin
                addr_d  = jmp_addr_i;
                state_d = ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_BOOT;
            addr_q        <= BOOT_ADDR;
            target_q      <= BOOT_ADDR;
            hold_q        <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_pc_q       <= BOOT_ADDR;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            target_q      <= target_d;
            hold_q        <= hold_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_pc_q       <= rd_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. Reset to NOP/BOOT_ADDR so the decoder outputs show
    // defined values while the FIFO is empty after reset. A word pushed in
    // a redirect cycle is written but becomes unreachable via the pointer
    // reset, which is what flushes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= NOP;
                pc_mem_q[i]    <= BOOT_ADDR;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= instr_rdata_i;
            pc_mem_q[wr_ptr_q]    <= rd_pc_q;
        end
    end

endmodule
